// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational alu between two requesters.
//   Ops arrive over req0/req1 valid/ready, operands are registered onto alu_a/alu_b/
//   alu_control, held ALU_LAT cycles, then alu_result is captured into rsp_result and
//   returned to the granted requester over rsp0/rsp1 valid/ready. busy = FSM not idle.
//   Define ALU_ARB_STATS_EN to add saturating per-requester grant counters
//   (grant_cnt0/grant_cnt1).
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int RES_W   = 17,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [RES_W-1:0]  alu_result,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state;
  logic       last_grant;
  logic       owner;
  logic [3:0] lat_cnt;
  logic       pick1;
  logic       xfer;
  // req1 wins when it is the only requester or when req0 was granted last
  assign pick1      = req1_valid && (!req0_valid || !last_grant);
  // ready is gated by rst_n so every output reads 0 while reset is held
  assign req0_ready = rst_n && state == IDLE && req0_valid && !pick1;
  assign req1_ready = rst_n && state == IDLE && pick1;
  assign xfer       = req0_ready || req1_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_cnt     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_result  <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      busy        <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (xfer) begin
          alu_a       <= pick1 ? req1_a : req0_a;
          alu_b       <= pick1 ? req1_b : req0_b;
          alu_control <= pick1 ? req1_op : req0_op;
          owner       <= pick1;
          last_grant  <= pick1;
          lat_cnt     <= 4'(ALU_LAT - 1);
          busy        <= 1'b1;
          state       <= EXEC;
`ifdef ALU_ARB_STATS_EN
          if (!pick1 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
          if (pick1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
`endif
        end
        EXEC: if (lat_cnt == 4'd0) begin
          rsp_result <= alu_result;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
        RESP: if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
